stacked_ntt_pipe: RTL and testbench

- Parametrised successor of the fixed two-core, four-bank stacked NTT wrapper.
- Owns NUM_CORES+2 dual_port_ram banks and rotates them through the slots input, core stage 0..NUM_CORES-1 and output, advancing one slot per accepted round.
- The NTT/pointwise cores sit outside the block and are connected through flattened per-core RAM buses, so each chain stage can be a different core type.
- Adds behaviour the fixed wrapper lacks: a round-ready handshake, overrun detection, per-slot valid tracking and an output-valid flag.

---
 rtl/stacked_ntt_pipe.sv | 215 +++++++++++++++++++++
 tb/tb_stacked_ntt_pipe.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/stacked_ntt_pipe.sv
// stacked_ntt_pipe: rotating bank pool for a chain of external NTT/pointwise
// cores. NUM_CORES+2 dual-port banks rotate through the input slot, each core
// stage and the output slot, one slot per accepted round. Round sequencing
// adds a ready handshake, overrun flagging, per-slot valid tracking and an
// output-valid flag.
module stacked_ntt_pipe #(
  parameter int NUM_CORES = 2,
  parameter int ADDR_W    = 9,
  parameter int DATA_W    = 16
) (
  input  logic                        i_clk,
  input  logic                        i_rst,
  input  logic                        i_en,
  input  logic                        i_start_round,
  output logic                        o_round_ready,
  output logic                        o_overrun,
  output logic                        o_round_done,
  output logic                        o_out_valid,
  input  logic                        i_in_we,
  input  logic [ADDR_W-1:0]           i_in_addr,
  input  logic [DATA_W-1:0]           i_in_di,
  input  logic [ADDR_W-1:0]           i_out_addr,
  output logic [DATA_W-1:0]           o_out_do,
  output logic [NUM_CORES-1:0]        o_core_start,
  input  logic [NUM_CORES-1:0]        i_core_done,
  input  logic [NUM_CORES-1:0]        i_core_wea,
  input  logic [NUM_CORES-1:0]        i_core_web,
  input  logic [NUM_CORES*ADDR_W-1:0] i_core_addra,
  input  logic [NUM_CORES*ADDR_W-1:0] i_core_addrb,
  input  logic [NUM_CORES*DATA_W-1:0] i_core_dia,
  input  logic [NUM_CORES*DATA_W-1:0] i_core_dib,
  output logic [NUM_CORES*DATA_W-1:0] o_core_doa,
  output logic [NUM_CORES*DATA_W-1:0] o_core_dob
);

  localparam int C     = NUM_CORES;
  localparam int B     = NUM_CORES + 2;
  localparam int PW    = $clog2(B + 1);
  localparam int DEPTH = 1 << ADDR_W;

  // Next slot in rotation order, wrapping at B-1.
  function automatic logic [PW-1:0] slot_inc(input logic [PW-1:0] p);
    if (p == PW'(B - 1)) slot_inc = '0;
    else                 slot_inc = p + PW'(1);
  endfunction

  // (p - d) mod B for 1 <= d < B.
  function automatic logic [PW-1:0] slot_back(input logic [PW-1:0] p,
                                              input logic [PW-1:0] d);
    if (p >= d) slot_back = p - d;
    else        slot_back = p + (PW'(B) - d);
  endfunction

  // Round sequencing state
  logic [PW-1:0] r_p;
  logic [C-1:0]  r_busy;
  logic [C:0]    r_valid;     // [k] = core stage k slot, [C] = output slot
  logic          r_filled;
  logic          r_round_ready;
  logic          r_overrun;
  logic          r_round_done;
  logic [C-1:0]  r_core_start;

  // Read-side bank selects, captured alongside the RAM addresses
  logic [PW-1:0] r_out_sel;
  logic [PW-1:0] r_core_sel [0:C-1];

  // Bank routing
  logic [PW-1:0]     w_out_bank;
  logic [PW-1:0]     w_core_bank [0:C-1];
  logic              w_wea   [0:B-1];
  logic              w_web   [0:B-1];
  logic [ADDR_W-1:0] w_addra [0:B-1];
  logic [ADDR_W-1:0] w_addrb [0:B-1];
  logic [DATA_W-1:0] w_dia   [0:B-1];
  logic [DATA_W-1:0] w_dib   [0:B-1];
  logic [DATA_W-1:0] w_doa   [0:B-1];
  logic [DATA_W-1:0] w_dob   [0:B-1];

  // Next-state terms
  logic          w_accept;
  logic [C:0]    w_new_valid;
  logic [C-1:0]  w_busy_nxt;
  logic [C-1:0]  w_start_nxt;

  // Slot-to-bank mapping for the output slot and each core stage
  always_comb begin
    w_out_bank = slot_inc(r_p);
    for (int k = 0; k < C; k++) begin
      w_core_bank[k] = slot_back(r_p, PW'(k + 1));
    end
  end

  // Route input, output and core buses onto their current banks; idle ports stay 0
  always_comb begin
    for (int b = 0; b < B; b++) begin
      w_wea[b]   = 1'b0;
      w_web[b]   = 1'b0;
      w_addra[b] = '0;
      w_addrb[b] = '0;
      w_dia[b]   = '0;
      w_dib[b]   = '0;
    end
    w_wea[r_p]          = i_in_we;
    w_addra[r_p]        = i_in_addr;
    w_dia[r_p]          = i_in_di;
    w_addra[w_out_bank] = i_out_addr;
    for (int k = 0; k < C; k++) begin
      w_wea[w_core_bank[k]]   = i_core_wea[k];
      w_web[w_core_bank[k]]   = i_core_web[k];
      w_addra[w_core_bank[k]] = i_core_addra[k*ADDR_W +: ADDR_W];
      w_addrb[w_core_bank[k]] = i_core_addrb[k*ADDR_W +: ADDR_W];
      w_dia[w_core_bank[k]]   = i_core_dia[k*DATA_W +: DATA_W];
      w_dib[w_core_bank[k]]   = i_core_dib[k*DATA_W +: DATA_W];
    end
  end

  // Bank pool: read-first dual-port RAMs with registered read data
  for (genvar b = 0; b < B; b++) begin : g_bank
    logic [DATA_W-1:0] r_mem [0:DEPTH-1];
    logic [DATA_W-1:0] r_doa;
    logic [DATA_W-1:0] r_dob;

    // Port A and port B writes
    always_ff @(posedge i_clk) begin
      if (i_en) begin
        if (w_wea[b]) r_mem[w_addra[b]] <= w_dia[b];
        if (w_web[b]) r_mem[w_addrb[b]] <= w_dib[b];
      end
    end

    // Registered reads; output latches clear on reset, contents do not
    always_ff @(posedge i_clk) begin
      if (i_rst) begin
        r_doa <= '0;
        r_dob <= '0;
      end else if (i_en) begin
        r_doa <= r_mem[w_addra[b]];
        r_dob <= r_mem[w_addrb[b]];
      end
    end

    assign w_doa[b] = r_doa;
    assign w_dob[b] = r_dob;
  end

  // Capture which bank each reader addressed so data follows the old bank across a rotation
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_out_sel <= '0;
      for (int k = 0; k < C; k++) r_core_sel[k] <= '0;
    end else if (i_en) begin
      r_out_sel  <= w_out_bank;
      r_core_sel <= w_core_bank;
    end
  end

  // Steer registered bank read data to the output port and each core
  always_comb begin
    o_out_do   = w_doa[r_out_sel];
    o_core_doa = '0;
    o_core_dob = '0;
    for (int k = 0; k < C; k++) begin
      o_core_doa[k*DATA_W +: DATA_W] = w_doa[r_core_sel[k]];
      o_core_dob[k*DATA_W +: DATA_W] = w_dob[r_core_sel[k]];
    end
  end

  // Next-state terms for the round sequencer
  always_comb begin
    w_accept    = i_start_round & r_round_ready;
    w_new_valid = {r_valid[C-1:0], r_filled | i_in_we};
    if (w_accept) begin
      w_busy_nxt  = w_new_valid[C-1:0];
      w_start_nxt = w_new_valid[C-1:0];
    end else begin
      w_busy_nxt  = r_busy & ~i_core_done;
      w_start_nxt = '0;
    end
  end

  // Round sequencer: pointer, valid shift, busy tracking and status pulses
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_p           <= '0;
      r_busy        <= '0;
      r_valid       <= '0;
      r_filled      <= 1'b0;
      r_round_ready <= 1'b1;
      r_overrun     <= 1'b0;
      r_round_done  <= 1'b0;
      r_core_start  <= '0;
    end else begin
      r_busy        <= w_busy_nxt;
      r_core_start  <= w_start_nxt;
      r_round_ready <= (w_busy_nxt == '0);
      r_round_done  <= (r_busy != '0) && (w_busy_nxt == '0);
      r_overrun     <= i_start_round & ~r_round_ready;
      if (w_accept) begin
        r_p      <= slot_inc(r_p);
        r_valid  <= w_new_valid;
        r_filled <= 1'b0;
      end else begin
        r_filled <= r_filled | i_in_we;
      end
    end
  end

  assign o_round_ready = r_round_ready;
  assign o_overrun     = r_overrun;
  assign o_round_done  = r_round_done;
  assign o_out_valid   = r_valid[C];
  assign o_core_start  = r_core_start;

endmodule

// File: tb/tb_stacked_ntt_pipe.sv
// Testbench for stacked_ntt_pipe with C=2: stub cores add 1 to the first NW
// words of their bank; a bank-level reference model predicts pointer, valid
// flags, core starts and output data.
module tb_stacked_ntt_pipe;

  localparam int C  = 2;
  localparam int B  = C + 2;
  localparam int AW = 9;
  localparam int DW = 16;
  localparam int NW = 16;

  logic clk = 1'b0;
  logic rst, en, start_round, in_we;
  logic [AW-1:0] in_addr, out_addr;
  logic [DW-1:0] in_di, out_do;
  logic round_ready, overrun, round_done, out_valid;
  logic [C-1:0] core_start, man_done, hold;
  logic abort;
  wire  [C-1:0] stub_done, core_done, core_wea, core_web;
  wire  [C*AW-1:0] core_addra, core_addrb;
  wire  [C*DW-1:0] core_dia, core_dib, core_doa, core_dob;

  assign core_done = stub_done | man_done;

  int n_checks = 0;
  int n_err    = 0;

  // reference model
  logic [DW-1:0] mem_m [B][NW];
  int            pm;
  bit [C:0]      vm;
  bit            fm;
  bit [C-1:0]    exp_start;

  always #5 clk = ~clk;

  stacked_ntt_pipe #(.NUM_CORES(C), .ADDR_W(AW), .DATA_W(DW)) dut (
    .i_clk(clk), .i_rst(rst), .i_en(en), .i_start_round(start_round),
    .o_round_ready(round_ready), .o_overrun(overrun), .o_round_done(round_done),
    .o_out_valid(out_valid), .i_in_we(in_we), .i_in_addr(in_addr), .i_in_di(in_di),
    .i_out_addr(out_addr), .o_out_do(out_do), .o_core_start(core_start),
    .i_core_done(core_done), .i_core_wea(core_wea), .i_core_web(core_web),
    .i_core_addra(core_addra), .i_core_addrb(core_addrb),
    .i_core_dia(core_dia), .i_core_dib(core_dib),
    .o_core_doa(core_doa), .o_core_dob(core_dob)
  );

  // Stub cores: on start, add 1 to words 0..NW-1 of their bank, then pulse done
  for (genvar g = 0; g < C; g++) begin : g_stub
    logic [AW-1:0] la, lb;
    logic [DW-1:0] ldib;
    logic          lweb, ldone;
    assign core_addra[g*AW +: AW] = la;
    assign core_addrb[g*AW +: AW] = lb;
    assign core_dia[g*DW +: DW]   = '0;
    assign core_dib[g*DW +: DW]   = ldib;
    assign core_wea[g]            = 1'b0;
    assign core_web[g]            = lweb;
    assign stub_done[g]           = ldone;
    initial begin
      la = '0; lb = '0; ldib = '0; lweb = 1'b0; ldone = 1'b0;
      forever begin
        @(negedge clk);
        if (core_start[g] === 1'b1 && !abort) begin
          for (int a = 0; a < NW; a++) begin
            la = AW'(a);
            @(negedge clk);
            lb = AW'(a); ldib = core_doa[g*DW +: DW] + 16'd1; lweb = 1'b1;
            @(negedge clk);
            lweb = 1'b0;
          end
          while (hold[g]) @(negedge clk);
          if (!abort) begin
            ldone = 1'b1;
            @(negedge clk);
            ldone = 1'b0;
          end
        end
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic int core_bank(input int k);
    return ((pm - 1 - k) % B + B) % B;
  endfunction

  // Model of one accepted round: shift valid flags, rotate, stubs add 1 on valid stages
  task automatic model_accept();
    bit nv0;
    nv0 = fm;
    for (int k = C; k >= 1; k--) vm[k] = vm[k-1];
    vm[0] = nv0;
    fm = 1'b0;
    pm = (pm + 1) % B;
    for (int k = 0; k < C; k++) begin
      exp_start[k] = vm[k];
      if (vm[k]) for (int a = 0; a < NW; a++) mem_m[core_bank(k)][a] += 16'd1;
    end
  endtask

  task automatic fill(input bit first);
    logic [DW-1:0] d;
    for (int a = 0; a < NW; a++) begin
      d = (first && a == 5) ? 16'h1234 : DW'($urandom);
      in_we = 1'b1; in_addr = AW'(a); in_di = d;
      mem_m[pm][a] = d;
      @(negedge clk);
    end
    in_we = 1'b0;
    fm = 1'b1;
  endtask

  task automatic read_out(input string tag);
    int ob;
    ob = (pm + 1) % B;
    for (int a = 0; a < NW; a++) begin
      out_addr = AW'(a);
      @(negedge clk);
      chk(tag, out_do, mem_m[ob][a]);
    end
  endtask

  task automatic wait_round_done(input string tag);
    bit seen;
    seen = 1'b0;
    for (int n = 0; n < 400 && !seen; n++) begin
      @(negedge clk);
      if (round_done === 1'b1) seen = 1'b1;
    end
    chk({tag, " round_done"}, seen, 1);
    chk({tag, " ready_after"}, round_ready, 1);
    @(negedge clk);
    chk({tag, " round_done_single"}, round_done, 0);
  endtask

  task automatic do_start(input string tag, input bit wait_done);
    start_round = 1'b1;
    @(negedge clk);
    start_round = 1'b0;
    model_accept();
    chk({tag, " p"}, dut.r_p, pm);
    chk({tag, " core_start"}, core_start, exp_start);
    chk({tag, " out_valid"}, out_valid, vm[C]);
    chk({tag, " ready"}, round_ready, exp_start == '0);
    if (wait_done && exp_start != '0) wait_round_done(tag);
    if (wait_done && vm[C]) read_out({tag, " out_data"});
  endtask

  // Global time limit
  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; en = 1'b1; start_round = 1'b0; in_we = 1'b0;
    in_addr = '0; in_di = '0; out_addr = '0; man_done = '0; hold = '0; abort = 1'b0;
    pm = 0; vm = '0; fm = 1'b0; exp_start = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("reset ready", round_ready, 1);
    chk("reset out_valid", out_valid, 0);
    chk("reset core_start", core_start, 0);
    chk("reset overrun", overrun, 0);
    chk("reset round_done", round_done, 0);
    chk("reset out_do", out_do, 0);
    chk("reset p", dut.r_p, 0);

    // rounds 1..3: filled polynomials travel through both stub cores
    fill(1'b1);
    do_start("r1", 1'b1);
    fill(1'b0);
    do_start("r2", 1'b1);
    fill(1'b0);
    do_start("r3", 1'b1);
    out_addr = AW'(5);
    @(negedge clk);
    chk("r3 out addr5", out_do, 32'h1236);

    // round 4 with core 1 held busy: refused start must pulse overrun only
    fill(1'b0);
    hold = 2'b10;
    do_start("r4", 1'b0);
    repeat (50) @(negedge clk);
    chk("ovr ready_low", round_ready, 0);
    start_round = 1'b1;
    @(negedge clk);
    start_round = 1'b0;
    chk("ovr pulse", overrun, 1);
    chk("ovr p_hold", dut.r_p, pm);
    chk("ovr no_start", core_start, 0);
    @(negedge clk);
    chk("ovr pulse_end", overrun, 0);
    hold = '0;
    wait_round_done("r4");
    read_out("r4 out_data");

    // five bubble rounds: pointer wraps, bubbles never start a core or flag output
    for (int i = 0; i < 5; i++) do_start($sformatf("bub%0d", i), 1'b1);

    // two filled rounds, then reset while both cores are busy
    fill(1'b0);
    do_start("r10", 1'b1);
    fill(1'b0);
    hold = 2'b11;
    do_start("r11", 1'b0);
    repeat (50) @(negedge clk);
    chk("rst busy ready_low", round_ready, 0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    pm = 0; vm = '0; fm = 1'b0;
    chk("midrst ready", round_ready, 1);
    chk("midrst out_valid", out_valid, 0);
    chk("midrst p", dut.r_p, 0);
    chk("midrst core_start", core_start, 0);
    abort = 1'b1;
    hold  = '0;
    repeat (3) @(negedge clk);
    abort = 1'b0;
    man_done = 2'b11;
    @(negedge clk);
    man_done = '0;
    chk("late done no_round_done", round_done, 0);
    chk("late done ready", round_ready, 1);
    @(negedge clk);
    chk("late done no_round_done2", round_done, 0);
    do_start("post_rst", 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
